vram_responder: RTL and testbench
=================================

VRAM_RESPONDER -- requirements
Module: vram_responder

Interface
REQ-001 The block SHALL be built with one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive video grants while a CPU request waits.
REQ-003 The block SHALL have port CLK_I, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port RST_I, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port V_ADR_I, input, [13:1]: video fetch word address.
REQ-006 The block SHALL have ports V_CYC_I and V_STB_I, input, 1 bit each: video bus cycle and strobe.
REQ-007 The block SHALL have port V_ACK_O, output, 1 bit: video acknowledge.
REQ-008 The block SHALL have port V_DAT_O, output, [15:0]: video read data.
REQ-009 The block SHALL have port C_ADR_I, input, [13:1]: CPU word address.
REQ-010 The block SHALL have port C_DAT_I, input, [15:0]: CPU write data.
REQ-011 The block SHALL have port C_SEL_I, input, [1:0]: byte lanes; bit 1 selects [15:8], bit 0 selects [7:0].
REQ-012 The block SHALL have ports C_WE_I, C_CYC_I and C_STB_I, input, 1 bit each: CPU write enable, bus cycle and strobe.
REQ-013 The block SHALL have port C_ACK_O, output, 1 bit: CPU acknowledge.
REQ-014 The block SHALL have port C_DAT_O, output, [15:0]: CPU read data.

Function
REQ-015 The block SHALL contain one single-port 8192 x 16 synchronous memory, word-addressed by ADR[13:1], covering addresses 0x0000-0x1FFF with no aliasing.
REQ-016 A port SHALL be requesting only while its CYC and STB are both high.
REQ-017 The FSM SHALL have three states: IDLE, VACK and CACK.
REQ-018 In IDLE with a request present, the block SHALL grant and access memory at that edge, then move to VACK or CACK.
REQ-019 V_ACK_O or C_ACK_O SHALL be high for exactly the one cycle spent in VACK or CACK, and read data SHALL be valid during that cycle.
REQ-020 VACK and CACK SHALL always return to IDLE and SHALL ignore requests, giving 2 cycles per access with request-to-ACK latency of 1 cycle.
REQ-021 When both ports request in IDLE, video SHALL win unless the starve counter equals STARVE_LIMIT, in which case the CPU SHALL win.
REQ-022 The starve counter SHALL be 3 bits and saturate at STARVE_LIMIT.
REQ-023 The starve counter SHALL increment on each video grant made while a CPU request is present.
REQ-024 The starve counter SHALL clear on a CPU grant, and SHALL clear in any IDLE cycle with no CPU request.
REQ-025 A CPU write SHALL update only the lanes selected by C_SEL_I; C_SEL_I=00 SHALL still be acknowledged with memory unchanged.
REQ-026 A CPU write SHALL leave C_DAT_O unchanged.
REQ-027 V_DAT_O and C_DAT_O SHALL each hold their last read value until that port's next read.
REQ-028 If CYC drops during VACK or CACK, the ACK pulse SHALL still occur, and any write SHALL already be committed.
REQ-029 A read and a write to the same address granted back-to-back SHALL be strictly ordered by grant order, with no bypass.

Reset
REQ-030 While RST_I=0, the FSM SHALL be forced to IDLE, the starve counter to 0, V_ACK_O and C_ACK_O to 0, and V_DAT_O and C_DAT_O to 0x0000, independent of clock.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted in VACK or CACK SHALL drop the ACK immediately; a write granted before reset SHALL remain committed.
REQ-033 The first grant SHALL be possible at the first rising edge after RST_I rises.

Verification
REQ-034 Single-port read: CPU writes 0xA55A to 0x0010 with SEL=11, then video reads 0x0010 -> V_ACK_O pulses 1 cycle after grant and V_DAT_O=0xA55A.
REQ-035 Byte lanes: write 0x1234 with SEL=11, then 0xFFFF with SEL=01 -> a CPU read returns 0x12FF.
REQ-036 Arbitration: both ports hold continuous requests -> grant sequence is V,V,V,V,C,V,V,V,V,C (STARVE_LIMIT=4).
REQ-037 Boundary addresses: writes to 0x0000 and 0x1FFF -> both read back distinctly, with no aliasing.
REQ-038 Reset mid-operation: RST_I=0 during CACK -> C_ACK_O=0 within the same cycle, outputs 0x0000, and the write data is present after reset.
REQ-039 Abort: video CYC drops in VACK -> one ACK pulse occurs, then IDLE, and a waiting CPU request is granted on the next edge.

Source files
------------

// File: rtl/vram_responder.sv
// Two-port VRAM arbiter: video and CPU share one 8192x16 synchronous RAM, video favoured, CPU anti-starvation.
// Memory accessed on the grant edge; ACK and read data follow one cycle later; each access occupies two cycles.
module vram_responder #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [13:1] V_ADR_I,
   input  logic        V_CYC_I,
   input  logic        V_STB_I,
   output logic        V_ACK_O,
   output logic [15:0] V_DAT_O,
   input  logic [13:1] C_ADR_I,
   input  logic [15:0] C_DAT_I,
   input  logic [1:0]  C_SEL_I,
   input  logic        C_WE_I,
   input  logic        C_CYC_I,
   input  logic        C_STB_I,
   output logic        C_ACK_O,
   output logic [15:0] C_DAT_O
);

   typedef enum logic [1:0] {IDLE, VACK, CACK} state_t;

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_t      state, state_nxt;
   logic [2:0]  starve, starve_nxt;
   logic        v_req, c_req;
   logic        grant_v, grant_c;
   logic        mem_we;
   logic [13:1] mem_adr;
   logic [15:0] mem [0:8191];

   assign v_req = V_CYC_I & V_STB_I;
   assign c_req = C_CYC_I & C_STB_I;

   always_comb begin
      state_nxt  = state;
      starve_nxt = starve;
      grant_v    = 1'b0;
      grant_c    = 1'b0;
      case (state)
         IDLE: begin
            if (c_req && (!v_req || starve == LIMIT)) begin
               grant_c    = 1'b1;
               state_nxt  = CACK;
               starve_nxt = 3'd0;
            end else if (v_req) begin
               grant_v   = 1'b1;
               state_nxt = VACK;
               // Count only video wins that actually made the CPU wait.
               if (!c_req)
                  starve_nxt = 3'd0;
               else if (starve < LIMIT)
                  starve_nxt = starve + 3'd1;
            end else begin
               starve_nxt = 3'd0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // RST_I gates the write so a request held through reset cannot touch memory.
   assign mem_we  = grant_c & C_WE_I & RST_I;
   assign mem_adr = grant_c ? C_ADR_I : V_ADR_I;

   always_ff @(posedge CLK_I) begin
      if (mem_we) begin
         if (C_SEL_I[1]) mem[mem_adr][15:8] <= C_DAT_I[15:8];
         if (C_SEL_I[0]) mem[mem_adr][7:0]  <= C_DAT_I[7:0];
      end
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state   <= IDLE;
         starve  <= 3'd0;
         V_DAT_O <= 16'h0000;
         C_DAT_O <= 16'h0000;
      end else begin
         state  <= state_nxt;
         starve <= starve_nxt;
         if (grant_v)
            V_DAT_O <= mem[mem_adr];
         if (grant_c && !C_WE_I)
            C_DAT_O <= mem[mem_adr];
      end
   end

   assign V_ACK_O = (state == VACK);
   assign C_ACK_O = (state == CACK);

endmodule

// File: tb/tb_vram_responder.sv
// Bench for vram_responder: directed vector table, corner sequences, and randomized traffic vs. a reference model.
module tb_vram_responder;

   localparam int LIMIT = 4;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b0;
   logic [12:0] V_ADR_I = '0;
   logic        V_CYC_I = 1'b0;
   logic        V_STB_I = 1'b0;
   logic        V_ACK_O;
   logic [15:0] V_DAT_O;
   logic [12:0] C_ADR_I = '0;
   logic [15:0] C_DAT_I = '0;
   logic [1:0]  C_SEL_I = '0;
   logic        C_WE_I = 1'b0;
   logic        C_CYC_I = 1'b0;
   logic        C_STB_I = 1'b0;
   logic        C_ACK_O;
   logic [15:0] C_DAT_O;

   vram_responder #(.STARVE_LIMIT(LIMIT)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .V_ADR_I(V_ADR_I), .V_CYC_I(V_CYC_I), .V_STB_I(V_STB_I),
      .V_ACK_O(V_ACK_O), .V_DAT_O(V_DAT_O),
      .C_ADR_I(C_ADR_I), .C_DAT_I(C_DAT_I), .C_SEL_I(C_SEL_I),
      .C_WE_I(C_WE_I), .C_CYC_I(C_CYC_I), .C_STB_I(C_STB_I),
      .C_ACK_O(C_ACK_O), .C_DAT_O(C_DAT_O)
   );

   always #5 CLK_I = ~CLK_I;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [12:0] adr;
      logic [1:0]  sel;
      logic [15:0] wdat;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [7];
   int   arb_exp [10];

   // Reference model state for the randomized phase.
   logic [15:0] mdl [16];
   int          busy;
   int          vwins;
   logic        exp_vack, exp_cack;
   logic [15:0] exp_vdat, exp_cdat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cpu_access(input logic we, input logic [1:0] sel, input logic [12:0] adr,
                             input logic [15:0] dat, output logic [15:0] rd);
      int n;
      @(negedge CLK_I);
      C_CYC_I = 1'b1; C_STB_I = 1'b1; C_WE_I = we;
      C_SEL_I = sel;  C_ADR_I = adr;  C_DAT_I = dat;
      n = 0;
      do begin
         @(negedge CLK_I);
         n++;
      end while (!C_ACK_O && n < 8);
      check("cpu_ack_latency", n, 1);
      rd = C_DAT_O;
      C_CYC_I = 1'b0; C_STB_I = 1'b0; C_WE_I = 1'b0;
   endtask

   task automatic video_read(input logic [12:0] adr, output logic [15:0] rd);
      int n;
      @(negedge CLK_I);
      V_CYC_I = 1'b1; V_STB_I = 1'b1; V_ADR_I = adr;
      n = 0;
      do begin
         @(negedge CLK_I);
         n++;
      end while (!V_ACK_O && n < 8);
      check("vid_ack_latency", n, 1);
      rd = V_DAT_O;
      V_CYC_I = 1'b0; V_STB_I = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      logic [15:0] last_cdat;
      logic        vr, cr;
      int          got, n;

      vecs[0] = '{13'h0010, 2'b11, 16'hA55A, 16'hA55A};
      vecs[1] = '{13'h0020, 2'b11, 16'h1234, 16'h1234};
      vecs[2] = '{13'h0020, 2'b01, 16'hFFFF, 16'h12FF};
      vecs[3] = '{13'h0020, 2'b10, 16'hAB00, 16'hABFF};
      vecs[4] = '{13'h0020, 2'b00, 16'h0000, 16'hABFF};
      vecs[5] = '{13'h0000, 2'b11, 16'h1111, 16'h1111};
      vecs[6] = '{13'h1FFF, 2'b11, 16'h2222, 16'h2222};
      for (int k = 0; k < 10; k++) arb_exp[k] = ((k % 5) == 4) ? 2 : 1;

      // Reset values
      repeat (3) @(negedge CLK_I);
      check("rst_vack", V_ACK_O, 0);
      check("rst_cack", C_ACK_O, 0);
      check("rst_vdat", V_DAT_O, 16'h0000);
      check("rst_cdat", C_DAT_O, 16'h0000);
      RST_I = 1'b1;

      // Vector table: write, confirm C_DAT_O untouched by the write, read back.
      last_cdat = 16'h0000;
      for (int i = 0; i < 7; i++) begin
         cpu_access(1'b1, vecs[i].sel, vecs[i].adr, vecs[i].wdat, rd);
         check("wr_holds_cdat", rd, last_cdat);
         cpu_access(1'b0, 2'b11, vecs[i].adr, 16'h0000, rd);
         check("vec_readback", rd, vecs[i].exp);
         last_cdat = vecs[i].exp;
      end
      cpu_access(1'b0, 2'b11, 13'h0000, 16'h0000, rd);
      check("alias_low", rd, 16'h1111);
      cpu_access(1'b0, 2'b11, 13'h1FFF, 16'h0000, rd);
      check("alias_high", rd, 16'h2222);

      video_read(13'h0010, rd);
      check("vid_read", rd, 16'hA55A);
      check("vid_read_cdat_hold", C_DAT_O, 16'h2222);
      cpu_access(1'b0, 2'b11, 13'h0020, 16'h0000, rd);
      check("vdat_hold", V_DAT_O, 16'hA55A);

      // Arbitration with both ports requesting continuously.
      @(negedge CLK_I);
      V_CYC_I = 1'b1; V_STB_I = 1'b1; V_ADR_I = 13'h0000;
      C_CYC_I = 1'b1; C_STB_I = 1'b1; C_WE_I = 1'b0; C_ADR_I = 13'h0010;
      for (int k = 0; k < 10; k++) begin
         got = 0;
         n = 0;
         while (got == 0 && n < 4) begin
            @(negedge CLK_I);
            n++;
            if (V_ACK_O) got = 1;
            else if (C_ACK_O) got = 2;
         end
         check("arb_grant", got, arb_exp[k]);
      end
      V_CYC_I = 1'b0; V_STB_I = 1'b0; C_CYC_I = 1'b0; C_STB_I = 1'b0;

      // Video aborts during its ACK cycle; waiting CPU served next.
      @(negedge CLK_I);
      V_CYC_I = 1'b1; V_STB_I = 1'b1; V_ADR_I = 13'h0010;
      @(negedge CLK_I);
      check("abort_vack", V_ACK_O, 1);
      V_CYC_I = 1'b0;
      C_CYC_I = 1'b1; C_STB_I = 1'b1; C_WE_I = 1'b0; C_ADR_I = 13'h0020;
      @(negedge CLK_I);
      check("abort_idle_vack", V_ACK_O, 0);
      check("abort_idle_cack", C_ACK_O, 0);
      @(negedge CLK_I);
      check("abort_cack", C_ACK_O, 1);
      check("abort_cdat", C_DAT_O, 16'hABFF);
      C_CYC_I = 1'b0; C_STB_I = 1'b0; V_STB_I = 1'b0;

      // Reset during CACK of a write.
      @(negedge CLK_I);
      C_CYC_I = 1'b1; C_STB_I = 1'b1; C_WE_I = 1'b1; C_SEL_I = 2'b11;
      C_ADR_I = 13'h0100; C_DAT_I = 16'h0ABC;
      @(negedge CLK_I);
      check("rstmid_cack_before", C_ACK_O, 1);
      RST_I = 1'b0;
      #1;
      check("rstmid_cack", C_ACK_O, 0);
      check("rstmid_cdat", C_DAT_O, 16'h0000);
      check("rstmid_vdat", V_DAT_O, 16'h0000);
      C_WE_I = 1'b0;
      repeat (2) @(negedge CLK_I);
      check("rstmid_hold_cack", C_ACK_O, 0);
      RST_I = 1'b1;
      @(negedge CLK_I);
      check("rst_first_grant", C_ACK_O, 1);
      check("rst_write_kept", C_DAT_O, 16'h0ABC);
      C_CYC_I = 1'b0; C_STB_I = 1'b0;

      // Randomized traffic on a small address window against the model.
      for (int a = 0; a < 16; a++) begin
         mdl[a] = 16'(a * 16'h1357 + 16'h0101);
         cpu_access(1'b1, 2'b11, 13'(a), mdl[a], rd);
      end
      cpu_access(1'b0, 2'b11, 13'd3, 16'h0000, rd);
      video_read(13'd5, rd);
      exp_cdat = mdl[3];
      exp_vdat = mdl[5];
      exp_vack = 1'b0;
      exp_cack = 1'b0;
      busy  = 0;
      vwins = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK_I);
         check("rnd_vack", V_ACK_O, exp_vack);
         check("rnd_cack", C_ACK_O, exp_cack);
         check("rnd_vdat", V_DAT_O, exp_vdat);
         check("rnd_cdat", C_DAT_O, exp_cdat);
         V_CYC_I = ($urandom_range(0, 99) < 85);
         V_STB_I = ($urandom_range(0, 99) < 90);
         C_CYC_I = ($urandom_range(0, 99) < 90);
         C_STB_I = ($urandom_range(0, 99) < 90);
         C_WE_I  = 1'($urandom_range(0, 1));
         C_SEL_I = 2'($urandom_range(0, 3));
         V_ADR_I = 13'($urandom_range(0, 15));
         C_ADR_I = 13'($urandom_range(0, 15));
         C_DAT_I = 16'($urandom);
         vr = V_CYC_I && V_STB_I;
         cr = C_CYC_I && C_STB_I;
         exp_vack = 1'b0;
         exp_cack = 1'b0;
         if (busy != 0) begin
            busy = 0;
         end else if (cr && (!vr || vwins == LIMIT)) begin
            busy = 1;
            exp_cack = 1'b1;
            vwins = 0;
            if (C_WE_I) begin
               if (C_SEL_I[1]) mdl[C_ADR_I[3:0]][15:8] = C_DAT_I[15:8];
               if (C_SEL_I[0]) mdl[C_ADR_I[3:0]][7:0]  = C_DAT_I[7:0];
            end else begin
               exp_cdat = mdl[C_ADR_I[3:0]];
            end
         end else if (vr) begin
            busy = 1;
            exp_vack = 1'b1;
            exp_vdat = mdl[V_ADR_I[3:0]];
            vwins = cr ? ((vwins < LIMIT) ? vwins + 1 : LIMIT) : 0;
         end else begin
            vwins = 0;
         end
      end
      V_CYC_I = 1'b0; V_STB_I = 1'b0; C_CYC_I = 1'b0; C_STB_I = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
